// File: rtl/multi_byte_add_seq_pkg.sv
// Shared types and helpers for the multi-byte add/subtract sequencer.
package add_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} add_seq_state_t;

  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/multi_byte_add_seq_if.sv
// Operand/result handshake bundle; master = producer/consumer, slave = sequencer.
interface multi_byte_add_seq_if #(parameter int unsigned NBYTES = 4);
  import add_seq_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [BYTE_W*NBYTES-1:0]   op_a;
  logic [BYTE_W*NBYTES-1:0]   op_b;
  logic                       sub;
  logic                       carry_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [BYTE_W*NBYTES-1:0]   sum;
  logic                       carry_out;
  logic                       overflow;

  modport master (
    output in_valid, op_a, op_b, sub, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/multi_byte_add_seq_lane.sv
// 8-bit ripple adder built from two chained 4-bit stages.
module byte_adder_lane (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [4:0] lo;
  logic [4:0] hi;

  assign lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
  assign hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, lo[4]};
  assign s  = {hi[3:0], lo[3:0]};
  assign co = hi[4];
endmodule

// File: rtl/multi_byte_add_seq.sv
// Byte-serial NBYTES-wide add/subtract on one shared 8-bit adder, LSB first.
// Optional signed overflow flag: define MULTI_BYTE_ADD_SEQ_OVF_EN.
module multi_byte_add_seq
  import add_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  multi_byte_add_seq_if.slave bus
);
  localparam int unsigned W  = BYTE_W * NBYTES;
  localparam int unsigned IW = idx_width(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  add_seq_state_t    state;
  logic [IW-1:0]     idx;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              carry_q;
  logic              carry_out_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [BYTE_W-1:0] lane_a;
  logic [BYTE_W-1:0] lane_b;
  logic [BYTE_W-1:0] lane_s;
  logic              lane_co;

  assign lane_a = a_q[idx*BYTE_W +: BYTE_W];
  assign lane_b = b_q[idx*BYTE_W +: BYTE_W];

  byte_adder_lane u_lane (
    .a  (lane_a),
    .b  (lane_b),
    .ci (carry_q),
    .s  (lane_s),
    .co (lane_co)
  );

  // B is stored pre-inverted for subtract so RUN never looks at the op again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready_q && bus.in_valid) begin
            a_q        <= bus.op_a;
            b_q        <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_q    <= bus.sub | bus.carry_in;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          sum_q[idx*BYTE_W +: BYTE_W] <= lane_s;
          carry_q                     <= lane_co;
          if (idx == LAST) begin
            carry_out_q <= lane_co;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULTI_BYTE_ADD_SEQ_OVF_EN
  logic overflow_q;

  // Carry into the top bit recovered from its operand and sum bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (state == RUN && idx == LAST) begin
      overflow_q <= (lane_a[BYTE_W-1] ^ lane_b[BYTE_W-1] ^ lane_s[BYTE_W-1]) ^ lane_co;
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Bench for multi_byte_add_seq: arithmetic reference model plus directed vectors.
module tb_multi_byte_add_seq;
  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sb;
    logic         ci;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_byte_add_seq_if #(.NBYTES(NB)) bus ();
  multi_byte_add_seq #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned accepted = 0;
  int unsigned delivered = 0;
  int unsigned bp_mode = 0;
  res_t q[$];
  int unsigned accq[$];
  logic seen = 1'b0;
  logic [W-1:0] last_s;
  logic last_co;
  logic last_ov;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic ovf_exp(input logic v);
`ifdef MULTI_BYTE_ADD_SEQ_OVF_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Whole-word arithmetic: A + B + cin, or A + ~B + 1 for subtract.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sb, input logic ci);
    logic [W-1:0] bb;
    logic [W:0]   cext;
    logic [W:0]   full;
    res_t r;
    bb      = sb ? ~b : b;
    cext    = '0;
    cext[0] = sb ? 1'b1 : ci;
    full    = {1'b0, a} + {1'b0, bb} + cext;
    r.s     = full[W-1:0];
    r.co    = full[W];
    r.ov    = ovf_exp((a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]));
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Single compare process: every cycle a result is visible it must match the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      accq.delete();
      seen = 1'b0;
    end else begin
      if (bus.out_valid) begin
        check("no_accept_in_done", bus.in_ready, 0);
        if (q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          check("sum", bus.sum, q[0].s);
          check("carry_out", bus.carry_out, q[0].co);
          check("overflow", bus.overflow, q[0].ov);
          if (!seen) begin
            check("latency", cyc - accq[0], NB);
            seen = 1'b1;
          end
          if (bus.out_ready) begin
            last_s  = bus.sum;
            last_co = bus.carry_out;
            last_ov = bus.overflow;
            void'(q.pop_front());
            void'(accq.pop_front());
            seen = 1'b0;
            delivered++;
          end
        end
      end else if (q.size() != 0) begin
        check("in_ready_busy", bus.in_ready, 0);
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.op_a, bus.op_b, bus.sub, bus.carry_in));
        accq.push_back(cyc + 1);
        accepted++;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sb, input logic ci);
    int unsigned n = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.sub = sb;
    bus.carry_in = ci;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        fail_now("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int unsigned target);
    int unsigned n = 0;
    while (delivered < target) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        fail_now("result_timeout");
        break;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_sum"}, bus.sum, 0);
    check({tag, "_carry_out"}, bus.carry_out, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
  endtask

  vec_t vecs[7];
  res_t m;
  logic [W-1:0] s0;
  logic c0;
  logic o0;
  int unsigned d0;
  int unsigned a0;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0};
    vecs[5] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[6] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};

    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.sub = 1'b0;
    bus.carry_in = 1'b0;

    #12;
    check_zero_outputs("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", bus.in_ready, 1);

    foreach (vecs[i]) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].sb, vecs[i].ci);
      check($sformatf("pin%0d_sum", i), m.s, vecs[i].es);
      check($sformatf("pin%0d_co", i), m.co, vecs[i].eco);
      check($sformatf("pin%0d_ov", i), m.ov, ovf_exp(vecs[i].eov));
      d0 = delivered;
      do_op(vecs[i].a, vecs[i].b, vecs[i].sb, vecs[i].ci);
      wait_result(d0 + 1);
      check($sformatf("vec%0d_sum", i), last_s, vecs[i].es);
      check($sformatf("vec%0d_co", i), last_co, vecs[i].eco);
      check($sformatf("vec%0d_ov", i), last_ov, ovf_exp(vecs[i].eov));
    end

    // Backpressure: hold DONE, poke in_valid, confirm nothing moves.
    bp_mode = 2;
    d0 = delivered;
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    begin
      int unsigned n = 0;
      while (!bus.out_valid) begin
        @(negedge clk);
        n++;
        if (n > 50) begin
          fail_now("stall_out_valid_timeout");
          break;
        end
      end
    end
    s0 = bus.sum;
    c0 = bus.carry_out;
    o0 = bus.overflow;
    check("stall_sum_value", s0, 32'h80000000);
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.op_a = $urandom;
      bus.sub = 1'b1;
      @(negedge clk);
      check("stall_sum", bus.sum, s0);
      check("stall_co", bus.carry_out, c0);
      check("stall_ov", bus.overflow, o0);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bp_mode = 0;
    @(posedge clk);
    #1;
    check("idle_after_release", bus.in_ready, 1);
    check("valid_dropped", bus.out_valid, 0);
    check("stall_delivered_once", delivered, d0 + 1);

    d0 = delivered;
    do_op(32'h00001000, 32'h00000234, 1'b0, 1'b1);
    do_op(32'h00010000, 32'h00000001, 1'b1, 1'b0);
    wait_result(d0 + 2);
    check("b2b_sum", last_s, 32'h0000FFFF);
    check("b2b_co", last_co, 1);

    // Abort mid-operation with a carry already in flight.
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_abort", bus.in_ready, 1);
    d0 = delivered;
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait_result(d0 + 1);
    check("post_abort_sum", last_s, 32'h23456789);
    check("post_abort_co", last_co, 0);

    bp_mode = 1;
    d0 = delivered;
    a0 = accepted;
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ~ra;
        1: rb = ra;
        2: ra = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_result(d0 + 500);
    check("sweep_accepted", accepted - a0, 500);
    check("sweep_delivered", delivered - d0, 500);
    check("sweep_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_byte_add_seq.md
# multi_byte_add_seq

Sequencer that performs wide add/subtract operations on one shared 8-bit ripple adder. It processes one byte per clock, least significant byte first, and chains the carry between bytes through a register. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side, so narrow adder hardware can serve NBYTES-wide arithmetic.

## Interface
- NBYTES, 4, operand width in bytes; legal range 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  producer has an operation
- in_ready  output  1  block can accept an operation
- op_a  input  8*NBYTES  operand A; byte 0 = bits [7:0] = least significant
- op_b  input  8*NBYTES  operand B
- sub  input  1  1 = A − B; 0 = A + B
- carry_in  input  1  carry into byte 0; ignored when sub=1
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- sum  output  8*NBYTES  result
- carry_out  output  1  carry out of the top byte; for sub, 1 = no borrow
- overflow  output  1  signed overflow (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid=1, latch the operands:
  - op_a.
  - op_b, inverted if sub=1.
  - carry register = sub ? 1 : carry_in.
  - byte index idx = 0.
  - Go to RUN.
- RUN: the shared adder takes byte idx of A, byte idx of B', and the carry register. On each edge:
  - Write the adder sum into result byte idx.
  - Load the adder carry-out into the carry register.
  - idx++.
  - When idx = NBYTES−1 is written, go to DONE.
- DONE: out_valid=1. sum, carry_out and overflow stay stable until out_ready=1, then go to IDLE.
- No same-cycle accept in DONE. in_ready is 0 in RUN and DONE.
- Arithmetic:
  - All byte arithmetic is modulo 256.
  - sum is modulo 2^(8*NBYTES).
  - carry_out = final carry register.
- idx counter is $clog2(NBYTES) bits. It never wraps past NBYTES−1.
- in_valid, op_a, op_b and sub are don't-care outside IDLE. Operands are used only from the latched copy.
- Reset asserted in any state:
  - Aborts the operation immediately.
  - in_ready=0, out_valid=0, sum=0, carry_out=0, overflow=0, FSM=IDLE.
  - The first cycle after reset release has in_ready=1.

## Timing
- Accept edge T (in_valid & in_ready). RUN occupies cycles T..T+NBYTES−1.
- out_valid rises at edge T+NBYTES. Latency is NBYTES cycles.
- Minimum issue interval is NBYTES+2 cycles (RUN×NBYTES, DONE≥1, IDLE≥1).
- out_ready held low stretches DONE indefinitely. Nothing is lost or changed.
- Reset values of all outputs: 0.
- in_ready becomes 1 in the first clock cycle after rst_n deasserts.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- MULTI_BYTE_ADD_SEQ_OVF_EN
  - Defined: overflow = carry into the MSB of the top byte XOR carry_out. It is computed in the final RUN cycle from the top-byte operand MSBs and sum MSB, then registered into DONE.
  - Undefined: the overflow port remains and is tied to 0. No overflow logic is synthesised.

## Structure
- Shared package add_seq_pkg:
  - State enum add_seq_state_t {IDLE, RUN, DONE}.
  - Constant BYTE_W = 8.
  - Function for idx width.
- One sub-module: byte_adder_lane, the 8-bit ripple adder.
  - Ports: a[7:0], b[7:0], ci, s[7:0], co.
  - Instantiated once and shared across all byte steps.
  - Built from two 4-bit full-adder stages.
- Everything else (FSM, idx counter, operand/result registers, carry register) lives in multi_byte_add_seq.

## Test plan
All scenarios use NBYTES=4.
- 0x000000FF + 0x00000001, sub=0, carry_in=0 -> sum 0x00000100, carry_out 0, out_valid exactly 4 cycles after accept.
- 0xFFFFFFFF + 0x00000001 -> sum 0x00000000, carry_out 1, overflow 0. 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, overflow 1 (0 if the macro is undefined).
- sub=1: 0x00000005 − 0x00000007 -> sum 0xFFFFFFFE, carry_out 0. 0x00000007 − 0x00000005 -> 0x00000002, carry_out 1. carry_in=1 with sub=1 is ignored.
- out_ready low for 3 cycles in DONE -> sum, carry_out and overflow stable, in_ready 0, in_valid pulses ignored. Release -> IDLE next edge, then back-to-back operations accepted.
- rst_n asserted at RUN idx=2 -> outputs immediately 0, FSM IDLE. Next operation 0x12345678 + 0x11111111 -> 0x23456789, with no carry leaked from the aborted operation.
- Random directed sweep, 500 operations with random sub/carry_in and random backpressure -> matches a reference model. Each operation accepted once and each result delivered once.
